// File: rtl/mpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpu_bus_pkg
// Description : Shared definitions for the MPU data-bus bridge. Contains the
//               bridge FSM state enum, address-region decode constants and
//               function, and default values for the peripheral wait-state
//               limit and the error read data.
// Revision    : 1.0 - initial release
// ============================================================================
package mpu_bus_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_RD   = 2'd1,
        ST_PER_WAIT = 2'd2,
        ST_ERR_RSP  = 2'd3
    } bus_state_t;

    // Address decode result
    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_PER      = 2'd1,
        REGION_UNMAPPED = 2'd2
    } region_t;

    // RAM lives in the bottom 64 KiB, peripherals in the top 16 MiB
    localparam logic [15:0] c_RAM_PREFIX      = 16'h0000;
    localparam logic [7:0]  c_PER_PREFIX      = 8'hFF;

    localparam logic [7:0]  c_DEF_PER_TIMEOUT = 8'd64;
    localparam logic [31:0] c_DEF_ERR_DATA    = 32'hDEAD_BEEF;

    // Only the upper half-word of the address participates in decode.
    function automatic region_t decode_region(input logic [15:0] addr_hi);
        region_t region;
        if (addr_hi == c_RAM_PREFIX) begin
            region = REGION_RAM;
        end else if (addr_hi[15:8] == c_PER_PREFIX) begin
            region = REGION_PER;
        end else begin
            region = REGION_UNMAPPED;
        end
        return region;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mpu_dbus_bridge
// Description : Bridges the CPU data bus to a single-cycle RAM port and a
//               wait-stated peripheral bus. One command outstanding at a time.
//               RAM writes complete in the acceptance cycle; RAM reads respond
//               one cycle later. Peripheral accesses hold their strobe until
//               per_ack or a wait-state timeout. Unmapped reads return
//               ERR_DATA with the error flag; unmapped writes are dropped.
// Ports       : clk, reset_n (async, active-low)
//               dbus_cmd_*  - CPU command channel (valid/ready handshake)
//               dbus_rsp_*  - read response strobe, data, error
//               ram_*       - RAM data port (combinational from command)
//               per_*       - registered peripheral request, per_rdata/per_ack
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_dbus_bridge
    import mpu_bus_pkg::*;
#(
    parameter logic [7:0]  PER_TIMEOUT = c_DEF_PER_TIMEOUT,
    parameter logic [31:0] ERR_DATA    = c_DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        reset_n,
    // CPU command channel
    input  logic        dbus_cmd_valid,
    output logic        dbus_cmd_ready,
    input  logic        dbus_cmd_wr,
    input  logic [31:0] dbus_cmd_address,
    input  logic [31:0] dbus_cmd_data,
    input  logic [1:0]  dbus_cmd_size,
    // CPU response channel
    output logic        dbus_rsp_ready,
    output logic [31:0] dbus_rsp_data,
    output logic        dbus_rsp_error,
    // RAM data port
    output logic [31:0] ram_addr,
    output logic [31:0] ram_d,
    output logic        ram_we,
    output logic        ram_cmd_valid,
    output logic [1:0]  ram_bytesel,
    input  logic [31:0] ram_q,
    // Peripheral bus
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic        per_rd,
    output logic        per_wr,
    output logic [1:0]  per_bytesel,
    input  logic [31:0] per_rdata,
    input  logic        per_ack
);

    bus_state_t  r_state;
    bus_state_t  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        r_per_rd;
    logic        r_per_wr;
    logic        w_per_rd_nxt;
    logic        w_per_wr_nxt;
    logic [31:0] r_per_addr;
    logic [31:0] r_per_wdata;
    logic [1:0]  r_per_bytesel;
    logic        w_latch_per;

    // Peripheral read responses are registered; RAM and unmapped read
    // responses are produced combinationally from the state.
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_error;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_data_nxt;
    logic        w_rsp_error_nxt;

    logic        w_accept;
    logic        w_timeout;
    logic        w_ram_we;
    logic        w_ram_rd;
    region_t     w_region;

    assign w_region       = decode_region(dbus_cmd_address[31:16]);
    assign dbus_cmd_ready = reset_n && (r_state == ST_IDLE);
    assign w_accept       = dbus_cmd_valid && dbus_cmd_ready;

    // Counter holds (wait cycle index - 1); the last allowed wait cycle is
    // the one where the counter would step up to PER_TIMEOUT.
    assign w_timeout      = (r_cnt == (PER_TIMEOUT - 8'd1));

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_per_rd_nxt    = r_per_rd;
        w_per_wr_nxt    = r_per_wr;
        w_latch_per     = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = 32'h0;
        w_rsp_error_nxt = 1'b0;
        w_ram_we        = 1'b0;
        w_ram_rd        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_region)
                        REGION_RAM: begin
                            if (dbus_cmd_wr) begin
                                w_ram_we = 1'b1;
                            end else begin
                                w_ram_rd    = 1'b1;
                                w_state_nxt = ST_RAM_RD;
                            end
                        end
                        REGION_PER: begin
                            w_latch_per  = 1'b1;
                            w_per_rd_nxt = !dbus_cmd_wr;
                            w_per_wr_nxt = dbus_cmd_wr;
                            w_cnt_nxt    = 8'd0;
                            w_state_nxt  = ST_PER_WAIT;
                        end
                        default: begin
                            // Unmapped writes vanish; reads get an error beat.
                            if (!dbus_cmd_wr) begin
                                w_state_nxt = ST_ERR_RSP;
                            end
                        end
                    endcase
                end
            end

            ST_RAM_RD: begin
                w_state_nxt = ST_IDLE;
            end

            ST_PER_WAIT: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (per_ack) begin
                    w_per_rd_nxt    = 1'b0;
                    w_per_wr_nxt    = 1'b0;
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = r_per_rd;
                    w_rsp_data_nxt  = r_per_rd ? per_rdata : 32'h0;
                end else if (w_timeout) begin
                    w_per_rd_nxt    = 1'b0;
                    w_per_wr_nxt    = 1'b0;
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = r_per_rd;
                    w_rsp_data_nxt  = r_per_rd ? ERR_DATA : 32'h0;
                    w_rsp_error_nxt = r_per_rd;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            ST_ERR_RSP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_per_rd      <= 1'b0;
            r_per_wr      <= 1'b0;
            r_per_addr    <= 32'h0;
            r_per_wdata   <= 32'h0;
            r_per_bytesel <= 2'b00;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 32'h0;
            r_rsp_error   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_per_rd    <= w_per_rd_nxt;
            r_per_wr    <= w_per_wr_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            if (w_latch_per) begin
                r_per_addr    <= dbus_cmd_address;
                r_per_wdata   <= dbus_cmd_data;
                r_per_bytesel <= dbus_cmd_size;
            end
        end
    end

    // RAM port follows the command directly; enables qualify it.
    assign ram_addr      = dbus_cmd_address;
    assign ram_d         = dbus_cmd_data;
    assign ram_bytesel   = dbus_cmd_size;
    assign ram_we        = w_ram_we;
    assign ram_cmd_valid = w_ram_rd;

    assign per_addr      = r_per_addr;
    assign per_wdata     = r_per_wdata;
    assign per_bytesel   = r_per_bytesel;
    assign per_rd        = r_per_rd;
    assign per_wr        = r_per_wr;

    // At most one response source is active in any cycle: the registered
    // peripheral response is only ever set when returning to IDLE.
    assign dbus_rsp_ready = (r_state == ST_RAM_RD) || (r_state == ST_ERR_RSP) || r_rsp_valid;
    assign dbus_rsp_error = (r_state == ST_ERR_RSP) || r_rsp_error;

    always_comb begin
        case (r_state)
            ST_RAM_RD:  dbus_rsp_data = ram_q;
            ST_ERR_RSP: dbus_rsp_data = ERR_DATA;
            default:    dbus_rsp_data = r_rsp_data;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mpu_dbus_bridge.md
MPU_DBUS_BRIDGE -- requirements
Module: mpu_dbus_bridge

Interface
REQ-001 Parameter PER_TIMEOUT, default 8'd64: peripheral wait-state limit in clk cycles.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout or unmapped read.
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dbus_cmd_valid  in  1  CPU command valid.
REQ-006 dbus_cmd_ready  out  1  command accepted when high together with valid.
REQ-007 dbus_cmd_wr  in  1  1 = write, 0 = read.
REQ-008 dbus_cmd_address  in  32  byte address.
REQ-009 dbus_cmd_data  in  32  write data, already lane-replicated by the CPU.
REQ-010 dbus_cmd_size  in  2  00 = byte, 01 = half, 1x = word.
REQ-011 dbus_rsp_ready  out  1  one-cycle read-response strobe.
REQ-012 dbus_rsp_data  out  32  read data, valid with dbus_rsp_ready.
REQ-013 dbus_rsp_error  out  1  error flag, valid with dbus_rsp_ready.
REQ-014 ram_addr / ram_d  out  32 / 32  RAM data-port address and write data.
REQ-015 ram_we / ram_cmd_valid  out  1 / 1  RAM write enable and read enable.
REQ-016 ram_bytesel  out  2  copy of dbus_cmd_size.
REQ-017 ram_q  in  32  RAM read data, valid one cycle after ram_cmd_valid.
REQ-018 per_addr / per_wdata  out  32 / 32  registered peripheral address and write data.
REQ-019 per_rd / per_wr / per_bytesel  out  1 / 1 / 2  registered peripheral strobes and size.
REQ-020 per_rdata / per_ack  in  32 / 1  peripheral read data and completion.

Function
REQ-021 Decode SHALL be: RAM when address[31:16]==16'h0000; PERIPH when address[31:24]==8'hFF; otherwise UNMAPPED.
REQ-022 The FSM SHALL have states IDLE, RAM_RD, PER_WAIT and ERR_RSP.
REQ-023 dbus_cmd_ready SHALL be 1 only in IDLE; only one command may be outstanding.
REQ-024 RAM write: in the acceptance cycle, ram_we=1 and ram_addr, ram_d and ram_bytesel are driven combinationally from the command; the FSM stays in IDLE; no response is issued.
REQ-025 RAM read: in the acceptance cycle, ram_cmd_valid=1; the FSM moves to RAM_RD; in RAM_RD, rsp_ready=1, rsp_data=ram_q, error=0; the FSM returns to IDLE. Latency is exactly 1 cycle.
REQ-026 Back-to-back RAM writes SHALL sustain one per cycle; a command following a RAM read waits one cycle.
REQ-027 ram_we and ram_cmd_valid SHALL be 0 whenever no RAM command is accepted in that cycle.
REQ-028 PERIPH access: on acceptance, register per_addr, per_wdata and per_bytesel, set per_rd or per_wr, clear the timeout counter, and move to PER_WAIT.
REQ-029 In PER_WAIT, the strobe SHALL stay high until per_ack or timeout, and the counter SHALL increment once per cycle.
REQ-030 per_ack in PER_WAIT SHALL drop the strobe the next cycle and return the FSM to IDLE; for a read, rsp_ready=1 with rsp_data=per_rdata and error=0 in that cycle.
REQ-031 Timeout occurs when the counter reaches PER_TIMEOUT without an ack: drop the strobe and return to IDLE. A read then responds with ERR_DATA and error=1; a write is discarded silently.
REQ-032 If per_ack and timeout fall in the same cycle, per_ack SHALL win.
REQ-033 per_ack outside PER_WAIT SHALL be ignored.
REQ-034 UNMAPPED read: accept, go to ERR_RSP, respond next cycle with ERR_DATA and error=1, then return to IDLE.
REQ-035 UNMAPPED write: accept and discard; no strobe, no response.
REQ-036 dbus_rsp_ready SHALL be high for exactly one cycle per read and never for writes.

Reset
REQ-037 While reset_n=0: FSM=IDLE, counter=0, and every registered output (per_*, dbus_rsp_*) is 0.
REQ-038 Reset asserted mid-access SHALL abort the access immediately; no response is issued after release.
REQ-039 dbus_cmd_ready SHALL be 0 while reset_n=0.

Structure
REQ-040 A shared package mpu_bus_pkg SHALL hold the state enum, region constants, default PER_TIMEOUT and ERR_DATA, and a decode function.
REQ-041 No sub-module is used; the block is a single FSM plus counter.

Verification
REQ-042 RAM write to 0x0000_0010, size 10, followed the next cycle by a read of the same address -> ram_we pulses in cycle 0; the read returns rsp_ready one cycle after acceptance with the written word.
REQ-043 Four back-to-back RAM writes -> dbus_cmd_ready stays high and ram_we is high for 4 consecutive cycles.
REQ-044 Read 0xFF00_0004, with per_ack given 3 cycles after per_rd and per_rdata=0x1234_5678 -> rsp_data=0x1234_5678, error=0, and per_rd is high for exactly 3 cycles.
REQ-045 Peripheral read with no ack, PER_TIMEOUT=8 -> rsp after 8 wait cycles with 0xDEAD_BEEF and error=1; per_rd drops.
REQ-046 Read 0x4000_0000 -> rsp_data=0xDEAD_BEEF and error=1 one cycle later; a write to the same address produces no strobe and no response.
REQ-047 reset_n pulsed low during PER_WAIT -> per_rd=0 immediately, no response after release, and dbus_cmd_ready=1 on the first cycle after release.
